// File: rtl/rename_commit_queue.sv
// rtl/rename_commit_queue.sv - in-order commit queue that frees retired rename mappings
module rename_commit_queue #(
  parameter int NAME_WIDTH = 5,
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENQ_E,
  input  logic [NAME_WIDTH-1:0] ENQ_NAME,
  output logic                  ENQ_READY,
  output logic [TAG_WIDTH-1:0]  ENQ_TAG,
  input  logic                  DONE_E_1,
  input  logic [TAG_WIDTH-1:0]  DONE_TAG_1,
  input  logic                  DONE_E_2,
  input  logic [TAG_WIDTH-1:0]  DONE_TAG_2,
  input  logic                  KILL,
  output logic [NAME_WIDTH-1:0] FREE_NAME,
  output logic                  FREE_E,
  output logic [TAG_WIDTH:0]    COUNT,
  output logic                  EMPTY
);

  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH+1)'(DEPTH);

  logic [NAME_WIDTH-1:0] name_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      done_q;
  logic [TAG_WIDTH-1:0]  head_q;
  logic [TAG_WIDTH-1:0]  tail_q;
  logic [TAG_WIDTH:0]    count_q;
  logic [TAG_WIDTH:0]    count_next;
  logic                  enq_fire;
  logic                  retire_fire;

  // Accept and retire decisions use only pre-edge state, so a retire never frees a slot for the same cycle.
  always_comb begin
    enq_fire    = ENQ_E && (count_q < DEPTH_C);
    retire_fire = valid_q[head_q] && done_q[head_q];
    count_next  = count_q;
    case ({enq_fire, retire_fire})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Name storage needs no reset: a slot's name is only read once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (!RST && !KILL && enq_fire) begin
      name_q[tail_q] <= ENQ_NAME;
    end
  end

  // Queue control: pointers, per-slot status and the free-port pulse; KILL drops entries silently.
  always_ff @(posedge CLK) begin
    if (RST || KILL) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      FREE_E  <= 1'b0;
      if (RST) begin
        FREE_NAME <= '0;
      end
    end else begin
      if (DONE_E_1 && valid_q[DONE_TAG_1]) begin
        done_q[DONE_TAG_1] <= 1'b1;
      end
      if (DONE_E_2 && valid_q[DONE_TAG_2]) begin
        done_q[DONE_TAG_2] <= 1'b1;
      end
      // Placed after completion so a completion aimed at the slot being filled loses.
      if (enq_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (retire_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        FREE_NAME       <= name_q[head_q];
        FREE_E          <= 1'b1;
      end else begin
        FREE_E <= 1'b0;
      end
      count_q <= count_next;
    end
  end

  // Status outputs derive from registered state only.
  always_comb begin
    ENQ_READY = (count_q < DEPTH_C);
    ENQ_TAG   = tail_q;
    COUNT     = count_q;
    EMPTY     = (count_q == '0);
  end

endmodule

// File: tb/tb_rename_commit_queue.sv
// tb/tb_rename_commit_queue.sv - directed self-checking bench for rename_commit_queue
module tb_rename_commit_queue;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENQ_E = 1'b0;
  logic [4:0] ENQ_NAME = '0;
  logic       ENQ_READY;
  logic [2:0] ENQ_TAG;
  logic       DONE_E_1 = 1'b0;
  logic [2:0] DONE_TAG_1 = '0;
  logic       DONE_E_2 = 1'b0;
  logic [2:0] DONE_TAG_2 = '0;
  logic       KILL = 1'b0;
  logic [4:0] FREE_NAME;
  logic       FREE_E;
  logic [3:0] COUNT;
  logic       EMPTY;

  int nchk = 0;
  int nerr = 0;

  rename_commit_queue #(.NAME_WIDTH(5), .DEPTH(8), .TAG_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST), .ENQ_E(ENQ_E), .ENQ_NAME(ENQ_NAME), .ENQ_READY(ENQ_READY),
    .ENQ_TAG(ENQ_TAG), .DONE_E_1(DONE_E_1), .DONE_TAG_1(DONE_TAG_1), .DONE_E_2(DONE_E_2),
    .DONE_TAG_2(DONE_TAG_2), .KILL(KILL), .FREE_NAME(FREE_NAME), .FREE_E(FREE_E),
    .COUNT(COUNT), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ENQ_E = 1'b0; DONE_E_1 = 1'b0; DONE_E_2 = 1'b0; KILL = 1'b0; RST = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (ENQ_READY !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", ENQ_READY); end
    nchk++; if (ENQ_TAG !== 3'd0) begin nerr++; $display("FAIL reset_tag: got %0d want 0", ENQ_TAG); end
    nchk++; if (COUNT !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    nchk++; if (EMPTY !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", EMPTY); end
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL reset_free_e: got %b want 0", FREE_E); end
    nchk++; if (FREE_NAME !== 5'd0) begin nerr++; $display("FAIL reset_free_name: got %0d want 0", FREE_NAME); end
  endtask

  task automatic test_enqueue();
    for (int i = 0; i < 3; i++) begin
      nchk++; if (ENQ_TAG !== 3'(i)) begin nerr++; $display("FAIL enq_tag[%0d]: got %0d want %0d", i, ENQ_TAG, i); end
      ENQ_E = 1'b1; ENQ_NAME = 5'(8 + i);
      tick();
      nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL enq_free_e[%0d]: got %b want 0", i, FREE_E); end
    end
    ENQ_E = 1'b0;
    nchk++; if (COUNT !== 4'd3) begin nerr++; $display("FAIL enq_count: got %0d want 3", COUNT); end
    nchk++; if (EMPTY !== 1'b0) begin nerr++; $display("FAIL enq_empty: got %b want 0", EMPTY); end
  endtask

  task automatic test_in_order_retire();
    DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd1;
    tick();
    DONE_TAG_1 = 3'd2;
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL ooo_no_free: got %b want 0", FREE_E); end
    DONE_TAG_1 = 3'd0;
    tick();
    DONE_E_1 = 1'b0;
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL retire_latency: got %b want 0", FREE_E); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++; if (FREE_E !== 1'b1) begin nerr++; $display("FAIL retire_e[%0d]: got %b want 1", i, FREE_E); end
      nchk++; if (FREE_NAME !== 5'(8 + i)) begin nerr++; $display("FAIL retire_name[%0d]: got %0d want %0d", i, FREE_NAME, 8 + i); end
    end
    nchk++; if (EMPTY !== 1'b1) begin nerr++; $display("FAIL retire_empty: got %b want 1", EMPTY); end
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL retire_pulse_end: got %b want 0", FREE_E); end
    nchk++; if (FREE_NAME !== 5'd10) begin nerr++; $display("FAIL retire_name_hold: got %0d want 10", FREE_NAME); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ENQ_E = 1'b1; ENQ_NAME = 5'(16 + i);
      tick();
    end
    nchk++; if (ENQ_READY !== 1'b0) begin nerr++; $display("FAIL full_ready: got %b want 0", ENQ_READY); end
    nchk++; if (COUNT !== 4'd8) begin nerr++; $display("FAIL full_count: got %0d want 8", COUNT); end
    ENQ_NAME = 5'd31;
    tick();
    ENQ_E = 1'b0;
    nchk++; if (COUNT !== 4'd8) begin nerr++; $display("FAIL full_drop_count: got %0d want 8", COUNT); end
    nchk++; if (ENQ_TAG !== 3'd0) begin nerr++; $display("FAIL full_drop_tag: got %0d want 0", ENQ_TAG); end
    DONE_E_2 = 1'b1; DONE_TAG_2 = 3'd0;
    tick();
    DONE_E_2 = 1'b0;
    ENQ_E = 1'b1; ENQ_NAME = 5'd30;
    tick();
    ENQ_E = 1'b0;
    nchk++; if (FREE_E !== 1'b1) begin nerr++; $display("FAIL full_retire_e: got %b want 1", FREE_E); end
    nchk++; if (FREE_NAME !== 5'd16) begin nerr++; $display("FAIL full_retire_name: got %0d want 16", FREE_NAME); end
    nchk++; if (COUNT !== 4'd7) begin nerr++; $display("FAIL no_bypass_count: got %0d want 7", COUNT); end
    nchk++; if (ENQ_READY !== 1'b1) begin nerr++; $display("FAIL full_ready_again: got %b want 1", ENQ_READY); end
    nchk++; if (ENQ_TAG !== 3'd0) begin nerr++; $display("FAIL wrap_tag: got %0d want 0", ENQ_TAG); end
    ENQ_E = 1'b1; ENQ_NAME = 5'd25;
    tick();
    ENQ_E = 1'b0;
    nchk++; if (ENQ_TAG !== 3'd1) begin nerr++; $display("FAIL wrap_tag_next: got %0d want 1", ENQ_TAG); end
    nchk++; if (COUNT !== 4'd8) begin nerr++; $display("FAIL wrap_count: got %0d want 8", COUNT); end
  endtask

  task automatic test_dual_done();
    do_reset();
    ENQ_E = 1'b1; ENQ_NAME = 5'd3;
    tick();
    ENQ_NAME = 5'd4;
    tick();
    ENQ_E = 1'b0;
    DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd0; DONE_E_2 = 1'b1; DONE_TAG_2 = 3'd0;
    tick();
    DONE_E_1 = 1'b0; DONE_E_2 = 1'b0;
    tick();
    nchk++; if (FREE_E !== 1'b1) begin nerr++; $display("FAIL dual_retire_e: got %b want 1", FREE_E); end
    nchk++; if (FREE_NAME !== 5'd3) begin nerr++; $display("FAIL dual_retire_name: got %0d want 3", FREE_NAME); end
    nchk++; if (COUNT !== 4'd1) begin nerr++; $display("FAIL dual_count: got %0d want 1", COUNT); end
    DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd5;
    tick();
    DONE_E_1 = 1'b0;
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL dual_single: got %b want 0", FREE_E); end
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL invalid_done_free: got %b want 0", FREE_E); end
    nchk++; if (COUNT !== 4'd1) begin nerr++; $display("FAIL invalid_done_count: got %0d want 1", COUNT); end
    // completion aimed at the slot being enqueued this cycle must be dropped
    ENQ_E = 1'b1; ENQ_NAME = 5'd6; DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd2;
    tick();
    ENQ_E = 1'b0;
    DONE_TAG_1 = 3'd1;
    tick();
    DONE_E_1 = 1'b0;
    tick();
    nchk++; if (FREE_NAME !== 5'd4 || FREE_E !== 1'b1) begin nerr++; $display("FAIL slot1_retire: got name %0d e %b want name 4 e 1", FREE_NAME, FREE_E); end
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL enq_wins_done: got %b want 0", FREE_E); end
    DONE_E_2 = 1'b1; DONE_TAG_2 = 3'd2;
    tick();
    DONE_E_2 = 1'b0;
    tick();
    nchk++; if (FREE_NAME !== 5'd6 || FREE_E !== 1'b1) begin nerr++; $display("FAIL slot2_retire: got name %0d e %b want name 6 e 1", FREE_NAME, FREE_E); end
    nchk++; if (EMPTY !== 1'b1) begin nerr++; $display("FAIL dual_empty: got %b want 1", EMPTY); end
  endtask

  task automatic test_kill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ENQ_E = 1'b1; ENQ_NAME = 5'(11 + i);
      tick();
    end
    ENQ_E = 1'b0;
    DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd0;
    tick();
    DONE_E_1 = 1'b0;
    KILL = 1'b1; ENQ_E = 1'b1; ENQ_NAME = 5'd20;
    tick();
    KILL = 1'b0; ENQ_E = 1'b0;
    nchk++; if (COUNT !== 4'd0) begin nerr++; $display("FAIL kill_count: got %0d want 0", COUNT); end
    nchk++; if (EMPTY !== 1'b1) begin nerr++; $display("FAIL kill_empty: got %b want 1", EMPTY); end
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL kill_free_e: got %b want 0", FREE_E); end
    nchk++; if (ENQ_TAG !== 3'd0) begin nerr++; $display("FAIL kill_tag: got %0d want 0", ENQ_TAG); end
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL kill_no_late_free: got %b want 0", FREE_E); end
    ENQ_E = 1'b1; ENQ_NAME = 5'd15;
    tick();
    ENQ_E = 1'b0;
    nchk++; if (ENQ_TAG !== 3'd1 || COUNT !== 4'd1) begin nerr++; $display("FAIL kill_reenq: got tag %0d count %0d want tag 1 count 1", ENQ_TAG, COUNT); end
    tick();
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL kill_reenq_not_done: got %b want 0", FREE_E); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ENQ_E = 1'b1; ENQ_NAME = 5'(1 + i);
      tick();
    end
    ENQ_E = 1'b0;
    DONE_E_1 = 1'b1; DONE_TAG_1 = 3'd0;
    tick();
    DONE_E_1 = 1'b0;
    RST = 1'b1; ENQ_E = 1'b1; ENQ_NAME = 5'd9;
    tick();
    RST = 1'b0; ENQ_E = 1'b0;
    nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL rst_pend_free_e: got %b want 0", FREE_E); end
    nchk++; if (COUNT !== 4'd0) begin nerr++; $display("FAIL rst_pend_count: got %0d want 0", COUNT); end
    nchk++; if (ENQ_TAG !== 3'd0) begin nerr++; $display("FAIL rst_pend_tag: got %0d want 0", ENQ_TAG); end
    nchk++; if (FREE_NAME !== 5'd0) begin nerr++; $display("FAIL rst_pend_name: got %0d want 0", FREE_NAME); end
    for (int i = 0; i < 4; i++) begin
      tick();
      nchk++; if (FREE_E !== 1'b0) begin nerr++; $display("FAIL rst_pend_quiet[%0d]: got %b want 0", i, FREE_E); end
    end
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_in_order_retire();
    test_full_wrap();
    test_dual_done();
    test_kill();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
